// File: rtl/frog_collision.sv
// Frog player stage: tracks frog position from key edges, detects car
// collisions and sequences lives, respawn delay, win and game over.
module frog_collision #(
    parameter int START_X   = 7,
    parameter int LIVES     = 3,
    parameter int HIT_DELAY = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic [15:0] car2,
    input  logic [15:0] car5,
    input  logic [15:0] car7,
    input  logic [15:0] car9,
    input  logic [15:0] car11,
    input  logic [15:0] car12,
    output logic [3:0]  frog_x,
    output logic [3:0]  frog_y,
    output logic [1:0]  lives,
    output logic        hit,
    output logic        win,
    output logic        game_over
);

    // state | meaning
    // PLAY  | frog accepts moves, collision and goal checked every cycle
    // HIT   | frog frozen while the respawn delay counts down
    // WIN   | frog reached row 15, everything held until reset
    // OVER  | last life lost, everything held until reset
    typedef enum logic [1:0] {PLAY, HIT, WIN, OVER} state_t;

    localparam int CW = (HIT_DELAY > 1) ? $clog2(HIT_DELAY) : 1;
    localparam logic [3:0]    START_COL  = 4'(START_X);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(HIT_DELAY - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    x_nxt, y_nxt;
    logic [1:0]    lives_nxt;
    logic [3:0]    key_q;
    logic          up_e, down_e, left_e, right_e;
    logic [15:0]   row;
    logic          occ;

    assign up_e    = key_up    & ~key_q[3];
    assign down_e  = key_down  & ~key_q[2];
    assign left_e  = key_left  & ~key_q[1];
    assign right_e = key_right & ~key_q[0];

    always_comb begin
        row = '0;
        case (frog_y)
            4'd2:    row = car2;
            4'd5:    row = car5;
            4'd7:    row = car7;
            4'd9:    row = car9;
            4'd11:   row = car11;
            4'd12:   row = car12;
            default: row = '0;
        endcase
    end

    // Column c lives in bit (15-c) of the row vector.
    assign occ       = row[4'd15 - frog_x];
    assign hit       = (state == PLAY) && occ;
    assign win       = (state == WIN);
    assign game_over = (state == OVER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PLAY;
            cnt    <= '0;
            frog_x <= START_COL;
            frog_y <= 4'd0;
            lives  <= LIVES_INIT;
            key_q  <= 4'b0000;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            frog_x <= x_nxt;
            frog_y <= y_nxt;
            lives  <= lives_nxt;
            key_q  <= {key_up, key_down, key_left, key_right};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_nxt     = frog_x;
        y_nxt     = frog_y;
        lives_nxt = lives;
        case (state)
            PLAY: begin
                // Collision wins over any move requested in the same cycle.
                if (occ) begin
                    state_nxt = HIT;
                    cnt_nxt   = CNT_LOAD;
                    lives_nxt = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                end else if (frog_y == 4'd15) begin
                    state_nxt = WIN;
                end else if (up_e) begin
                    y_nxt = frog_y + 4'd1;
                end else if (down_e) begin
                    if (frog_y != 4'd0) y_nxt = frog_y - 4'd1;
                end else if (left_e) begin
                    if (frog_x != 4'd0) x_nxt = frog_x - 4'd1;
                end else if (right_e) begin
                    if (frog_x != 4'd15) x_nxt = frog_x + 4'd1;
                end
            end
            HIT: begin
                if (cnt == '0) begin
                    if (lives == 2'd0) begin
                        state_nxt = OVER;
                    end else begin
                        state_nxt = PLAY;
                        x_nxt     = START_COL;
                        y_nxt     = 4'd0;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

endmodule

// File: tb/tb_frog_collision.sv
// Directed bench for frog_collision: reset, collision, clamping/priority,
// win, game over, car moving onto the frog and reset during HIT.
module tb_frog_collision;

    localparam int HD = 4;

    logic        clk;
    logic        reset;
    logic        key_up, key_down, key_left, key_right;
    logic [15:0] car2, car5, car7, car9, car11, car12;
    logic [3:0]  frog_x, frog_y;
    logic [1:0]  lives;
    logic        hit, win, game_over;

    int total;
    int bad;

    frog_collision #(.START_X(7), .LIVES(3), .HIT_DELAY(HD)) dut (
        .clk(clk), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .car2(car2), .car5(car5), .car7(car7), .car9(car9), .car11(car11), .car12(car12),
        .frog_x(frog_x), .frog_y(frog_y), .lives(lives),
        .hit(hit), .win(win), .game_over(game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
        car2 = '0; car5 = '0; car7 = '0; car9 = '0; car11 = '0; car12 = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic press_up();    key_up = 1;    tick(); key_up = 0;    tick(); endtask
    task automatic press_down();  key_down = 1;  tick(); key_down = 0;  tick(); endtask
    task automatic press_left();  key_left = 1;  tick(); key_left = 0;  tick(); endtask
    task automatic press_right(); key_right = 1; tick(); key_right = 0; tick(); endtask

    task automatic test_reset();
        do_reset();
        press_up();
        press_right();
        total++;
        if (frog_x !== 4'd8 || frog_y !== 4'd1) begin
            bad++; $display("FAIL pre_reset_pos got=(%0d,%0d) exp=(8,1)", frog_x, frog_y);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (frog_x !== 4'd7 || frog_y !== 4'd0 || lives !== 2'd3) begin
            bad++; $display("FAIL async_reset_pos got=(%0d,%0d) lives=%0d exp=(7,0) lives=3", frog_x, frog_y, lives);
        end
        total++;
        if (hit !== 1'b0 || win !== 1'b0 || game_over !== 1'b0) begin
            bad++; $display("FAIL async_reset_flags got hit=%b win=%b over=%b exp=000", hit, win, game_over);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        car2 = 16'b1110000110011111;
        key_up = 1; tick();
        total++;
        if (frog_y !== 4'd1 || hit !== 1'b0) begin
            bad++; $display("FAIL coll_row1 got y=%0d hit=%b exp y=1 hit=0", frog_y, hit);
        end
        key_up = 0; tick();
        key_up = 1; tick();
        total++;
        if (frog_y !== 4'd2 || hit !== 1'b1 || lives !== 2'd3) begin
            bad++; $display("FAIL coll_hit got y=%0d hit=%b lives=%0d exp y=2 hit=1 lives=3", frog_y, hit, lives);
        end
        key_up = 0; tick();
        total++;
        if (hit !== 1'b0 || lives !== 2'd2) begin
            bad++; $display("FAIL coll_pulse got hit=%b lives=%0d exp hit=0 lives=2", hit, lives);
        end
        key_right = 1;
        for (int i = 0; i < HD - 1; i++) tick();
        total++;
        if (frog_x !== 4'd7 || frog_y !== 4'd2 || hit !== 1'b0) begin
            bad++; $display("FAIL coll_frozen got=(%0d,%0d) hit=%b exp=(7,2) hit=0", frog_x, frog_y, hit);
        end
        tick();
        total++;
        if (frog_x !== 4'd7 || frog_y !== 4'd0 || lives !== 2'd2) begin
            bad++; $display("FAIL coll_respawn got=(%0d,%0d) lives=%0d exp=(7,0) lives=2", frog_x, frog_y, lives);
        end
        key_right = 0; tick();
        press_up();
        total++;
        if (frog_y !== 4'd1 || frog_x !== 4'd7) begin
            bad++; $display("FAIL coll_play_again got=(%0d,%0d) exp=(7,1)", frog_x, frog_y);
        end
    endtask

    task automatic test_clamp_priority();
        do_reset();
        for (int i = 0; i < 9; i++) press_left();
        total++;
        if (frog_x !== 4'd0) begin
            bad++; $display("FAIL clamp_left got x=%0d exp x=0", frog_x);
        end
        key_up = 1; key_right = 1; tick();
        total++;
        if (frog_y !== 4'd1 || frog_x !== 4'd0) begin
            bad++; $display("FAIL prio_up_right got=(%0d,%0d) exp=(0,1)", frog_x, frog_y);
        end
        key_up = 0; key_right = 0; tick();
        total++;
        if (frog_x !== 4'd0) begin
            bad++; $display("FAIL prio_not_queued got x=%0d exp x=0", frog_x);
        end
        key_right = 1;
        for (int i = 0; i < 10; i++) tick();
        key_right = 0; tick();
        total++;
        if (frog_x !== 4'd1) begin
            bad++; $display("FAIL held_key got x=%0d exp x=1", frog_x);
        end
        for (int i = 0; i < 15; i++) press_right();
        total++;
        if (frog_x !== 4'd15) begin
            bad++; $display("FAIL clamp_right got x=%0d exp x=15", frog_x);
        end
        key_down = 1; key_left = 1; tick();
        key_down = 0; key_left = 0; tick();
        total++;
        if (frog_y !== 4'd0 || frog_x !== 4'd15) begin
            bad++; $display("FAIL prio_down_left got=(%0d,%0d) exp=(15,0)", frog_x, frog_y);
        end
        press_down();
        total++;
        if (frog_y !== 4'd0) begin
            bad++; $display("FAIL clamp_down got y=%0d exp y=0", frog_y);
        end
    endtask

    task automatic test_win();
        do_reset();
        for (int i = 0; i < 14; i++) press_up();
        key_up = 1; tick();
        total++;
        if (frog_y !== 4'd15 || win !== 1'b0) begin
            bad++; $display("FAIL win_reach got y=%0d win=%b exp y=15 win=0", frog_y, win);
        end
        key_up = 0; tick();
        total++;
        if (win !== 1'b1 || game_over !== 1'b0) begin
            bad++; $display("FAIL win_level got win=%b over=%b exp win=1 over=0", win, game_over);
        end
        press_down();
        press_left();
        total++;
        if (frog_x !== 4'd7 || frog_y !== 4'd15 || win !== 1'b1 || lives !== 2'd3) begin
            bad++; $display("FAIL win_hold got=(%0d,%0d) win=%b lives=%0d exp=(7,15) win=1 lives=3", frog_x, frog_y, win, lives);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        car2 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            press_up();
            key_up = 1; tick();
            total++;
            if (hit !== 1'b1 || frog_y !== 4'd2) begin
                bad++; $display("FAIL go_hit%0d got hit=%b y=%0d exp hit=1 y=2", i, hit, frog_y);
            end
            key_up = 0; tick();
            total++;
            if (lives !== 2'(2 - i) || hit !== 1'b0) begin
                bad++; $display("FAIL go_lives%0d got lives=%0d hit=%b exp lives=%0d hit=0", i, lives, hit, 2 - i);
            end
            for (int k = 0; k < HD - 1; k++) tick();
            total++;
            if (game_over !== 1'b0) begin
                bad++; $display("FAIL go_early%0d got over=%b exp over=0", i, game_over);
            end
            tick();
            if (i < 2) begin
                total++;
                if (frog_y !== 4'd0 || game_over !== 1'b0) begin
                    bad++; $display("FAIL go_respawn%0d got y=%0d over=%b exp y=0 over=0", i, frog_y, game_over);
                end
            end else begin
                total++;
                if (game_over !== 1'b1 || frog_y !== 4'd2 || frog_x !== 4'd7) begin
                    bad++; $display("FAIL go_final got over=%b pos=(%0d,%0d) exp over=1 pos=(7,2)", game_over, frog_x, frog_y);
                end
            end
        end
        press_up();
        press_left();
        total++;
        if (game_over !== 1'b1 || frog_y !== 4'd2 || frog_x !== 4'd7 || lives !== 2'd0 || hit !== 1'b0) begin
            bad++; $display("FAIL go_hold got over=%b pos=(%0d,%0d) lives=%0d hit=%b exp over=1 pos=(7,2) lives=0 hit=0", game_over, frog_x, frog_y, lives, hit);
        end
    endtask

    task automatic test_car_onto_frog_and_reset();
        do_reset();
        for (int i = 0; i < 5; i++) press_up();
        tick();
        total++;
        if (frog_y !== 4'd5 || hit !== 1'b0) begin
            bad++; $display("FAIL onto_idle got y=%0d hit=%b exp y=5 hit=0", frog_y, hit);
        end
        car5 = 16'h0100;
        #1;
        total++;
        if (hit !== 1'b1) begin
            bad++; $display("FAIL onto_hit got hit=%b exp hit=1", hit);
        end
        tick();
        car5 = 16'h0000;
        total++;
        if (lives !== 2'd2 || hit !== 1'b0) begin
            bad++; $display("FAIL onto_lives got lives=%0d hit=%b exp lives=2 hit=0", lives, hit);
        end
        tick();
        key_up = 1;
        #2 reset = 1'b1;
        #1;
        total++;
        if (lives !== 2'd3 || frog_x !== 4'd7 || frog_y !== 4'd0 || hit !== 1'b0) begin
            bad++; $display("FAIL midhit_reset got lives=%0d pos=(%0d,%0d) hit=%b exp lives=3 pos=(7,0) hit=0", lives, frog_x, frog_y, hit);
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (frog_y !== 4'd1 || frog_x !== 4'd7) begin
            bad++; $display("FAIL held_through_reset got=(%0d,%0d) exp=(7,1)", frog_x, frog_y);
        end
        key_up = 0; tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
        car2 = '0; car5 = '0; car7 = '0; car9 = '0; car11 = '0; car12 = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_collision();
        test_clamp_priority();
        test_win();
        test_game_over();
        test_car_onto_frog_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frog_collision.md
Name: frog_collision

Overview:
- Player-side stage directly downstream of the car-row generator.
- Consumes the six 16-bit car occupancy rows, tracks the frog position on the 16x16 grid from key presses, and detects frog/car collisions.
- Manages lives, respawn delay, win and game-over status.
- Outputs feed the draw/display logic.

Parameters:
- START_X, 7: frog column after reset and after each respawn (row is always 0).
- LIVES, 3: lives loaded at reset. Legal range 1..3.
- HIT_DELAY, 1500: clock cycles the frog stays frozen after a hit before respawn or game over. Must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- key_up  input  1  level, synchronous to clk. Rising edge requests y+1.
- key_down  input  1  level, synchronous to clk. Rising edge requests y-1.
- key_left  input  1  level, synchronous to clk. Rising edge requests x-1.
- key_right  input  1  level, synchronous to clk. Rising edge requests x+1.
- car2, car5, car7, car9, car11, car12  input  16 each  car occupancy of rows 2, 5, 7, 9, 11, 12. Column c maps to bit (15-c); 1 = car present.
- frog_x  output  4  frog column.
- frog_y  output  4  frog row. 0 = start, 15 = goal.
- lives  output  2  remaining lives.
- hit  output  1  one-cycle pulse on the cycle the HIT state is entered.
- win  output  1  level; high while in the WIN state.
- game_over  output  1  level; high while in the OVER state.

Behaviour:
- Reset (asynchronous, takes effect immediately and at any time, including mid-HIT):
  - frog_x = START_X, frog_y = 0, lives = LIVES.
  - hit = 0, win = 0, game_over = 0.
  - state = PLAY, delay counter = 0.
  - Key-history registers = 0, so a key held through reset deassertion counts as a fresh edge on the first clock.
- Edge detection:
  - Each key is registered every cycle.
  - A press is a cycle where key = 1 and the previous sample = 0.
  - Only one move is accepted per cycle. Priority: up > down > left > right. Lower-priority simultaneous edges are discarded, not queued.
- Moves:
  - Applied at the clock edge that samples the key rise, so frog_x/frog_y change one cycle after the key rises.
  - Moves off the grid are ignored (x=0 with left, x=15 with right, y=0 with down); the position is unchanged.
- Occupancy:
  - occ = 1 when frog_y is one of {2,5,7,9,11,12} and bit (15-frog_x) of that row's car input is 1.
  - All other rows are always safe.
  - Evaluated combinationally from the registered position and the current car inputs.
- States:
  - PLAY:
    - If occ: go to HIT, assert hit for 1 cycle, decrement lives, load counter = HIT_DELAY-1. The move request in that cycle is ignored (collision beats movement).
    - Else if frog_y == 15: go to WIN.
    - Else: process the move.
    - A car shifting onto the frog's cell counts as a hit exactly like the frog moving onto a car.
  - HIT:
    - Keys ignored, position frozen, counter decrements each cycle.
    - At counter == 0: if lives == 0, go to OVER with the position held. Otherwise set frog_x = START_X, frog_y = 0, and return to PLAY.
  - WIN and OVER:
    - Terminal; keys ignored; all outputs held until reset.
- Lives:
  - Never decrements below 0.
  - A hit taken with lives = 1 yields lives = 0 and then OVER after the delay.
- Latency:
  - key rise at edge n -> position updated at edge n+1.
  - If the new cell is occupied, hit asserts during the cycle after edge n+1, and state = HIT from edge n+2.

Test Plan:
- Reset: assert reset mid-cycle -> frog_x=7, frog_y=0, lives=3, hit/win/game_over=0 immediately, without waiting for a clk edge.
- Collision: hold car2=16'b1110000110011111, other rows 0; pulse key_up twice -> frog_y=2 and bit 8 = 1, so hit pulses for exactly 1 cycle and lives=2. After HIT_DELAY cycles -> frog at (7,0), state PLAY.
- Clamp and priority:
  - Pulse key_left 9 times -> frog_x reaches 0 and stays 0.
  - key_up and key_right rising in the same cycle -> only y increments, x unchanged.
  - A key held high for 10 cycles produces exactly one move.
- Win: all car rows 0; 15 key_up pulses -> frog_y=15, win=1 on the following cycle. Further key pulses cause no change.
- Game over: HIT_DELAY=4, car2=16'hFFFF. Repeatedly step into row 2 -> lives goes 2, 1, 0. game_over=1 four cycles after the third hit, and the frog stays at row 2.
- Car moves onto frog and reset mid-HIT:
  - Frog idle at (7,5) with car5 bit 8 = 0. Change car5 so bit 8 = 1 -> hit on the next cycle.
  - Assert reset during HIT -> lives=3, state PLAY, frog at (7,0).
